// File: rtl/maxpool2x2_sched.sv
// rtl/maxpool2x2_sched.sv - 2x2 max-pool scheduler: pairs even-row pixels, presents windows to the
// external comparator tree on odd rows and emits the pooled stream with last/done.
module maxpool2x2_sched #(
  parameter int WIDTH    = 8,
  parameter int MAX_COLS = 416,
  parameter int DIM_W    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_cols,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] win_1_1,
  output logic [WIDTH-1:0] win_1_2,
  output logic [WIDTH-1:0] win_2_1,
  output logic [WIDTH-1:0] win_2_2,
  output logic             win_valid,
  input  logic [WIDTH-1:0] max_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = MAX_COLS / 2;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [DIM_W-1:0]   cols, rows, col, row;
  logic [WIDTH-1:0]   held;
  logic [2*WIDTH-1:0] pair_buf [DEPTH];
  logic [AW-1:0]      pidx;
  logic               xfer, row_end, last_px, win_last;
  logic [PIPE_LAT-1:0] vsr, lsr;

  assign xfer    = in_valid && (state == RUN);
  assign row_end = (col == cols - DIM_W'(1));
  assign last_px = row_end && (row == rows - DIM_W'(1));
  assign pidx    = col[AW:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (xfer && last_px) state_nx = DRAIN;
      end
      // The final window is still in win_valid when DRAIN is entered, so it counts as in flight.
      DRAIN: if (!win_valid && (vsr == '0)) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Even rows only write, odd rows only read, so no read/write collision on an index.
  always_ff @(posedge clk) begin
    if (xfer && col[0] && !row[0]) pair_buf[pidx] <= {held, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols      <= '0;
      rows      <= '0;
      col       <= '0;
      row       <= '0;
      held      <= '0;
      win_1_1   <= '0;
      win_1_2   <= '0;
      win_2_1   <= '0;
      win_2_2   <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      vsr       <= '0;
      lsr       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      if (state == IDLE && start) begin
        cols <= cfg_cols & ~DIM_W'(1);
        rows <= cfg_rows & ~DIM_W'(1);
        col  <= '0;
        row  <= '0;
      end
      if (xfer) begin
        if (row_end) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
        if (!col[0]) begin
          held <= in_data;
        end else if (row[0]) begin
          win_1_1   <= pair_buf[pidx][2*WIDTH-1:WIDTH];
          win_1_2   <= pair_buf[pidx][WIDTH-1:0];
          win_2_1   <= held;
          win_2_2   <= in_data;
          win_valid <= 1'b1;
          win_last  <= last_px;
        end
      end
      vsr[0] <= win_valid;
      lsr[0] <= win_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vsr[i] <= vsr[i-1];
        lsr[i] <= lsr[i-1];
      end
      out_valid <= vsr[PIPE_LAT-1];
      out_last  <= vsr[PIPE_LAT-1] && lsr[PIPE_LAT-1];
      if (vsr[PIPE_LAT-1]) out_data <= max_in;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_sched.sv
// tb/tb_maxpool2x2_sched.sv - self-checking bench for maxpool2x2_sched with a behavioural
// comparator tree and a frame-level pooling reference model.
module tb_maxpool2x2_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   cfg_cols = '0;
  logic [9:0]   cfg_rows = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic [W-1:0] win_1_1, win_1_2, win_2_1, win_2_2;
  logic         win_valid;
  logic [W-1:0] max_in;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  maxpool2x2_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .win_1_1(win_1_1), .win_1_2(win_1_2), .win_2_1(win_2_1), .win_2_2(win_2_2),
    .win_valid(win_valid), .max_in(max_in), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Two-level registered comparator tree, latency 2.
  logic signed [W-1:0] l1a = '0, l1b = '0, max_r = '0;
  always @(posedge clk) begin
    l1a   <= ($signed(win_1_1) > $signed(win_1_2)) ? win_1_1 : win_1_2;
    l1b   <= ($signed(win_2_1) > $signed(win_2_2)) ? win_2_1 : win_2_2;
    max_r <= (l1a > l1b) ? l1a : l1b;
  end
  assign max_in = max_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_viol = 0;
  int win_cyc[$], out_cyc[$], done_cyc[$], out_q[$], win_q[$];
  bit last_q[$];
  int frame_pix[$];

  always @(negedge clk) begin
    cyc++;
    if (win_valid) begin
      win_cyc.push_back(cyc);
      win_q.push_back(int'($signed(win_1_1)));
      win_q.push_back(int'($signed(win_1_2)));
      win_q.push_back(int'($signed(win_2_1)));
      win_q.push_back(int'($signed(win_2_2)));
    end
    if (out_valid) begin
      out_cyc.push_back(cyc);
      out_q.push_back(int'($signed(out_data)));
      last_q.push_back(out_last);
    end
    if (done) done_cyc.push_back(cyc);
    if (in_ready && (!busy || done)) rdy_viol++;
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode, input int n);
    frame_pix.delete();
    for (int i = 0; i < n; i++)
      frame_pix.push_back(mode == 0 ? i : int'($urandom_range(255)) - 128);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after done (or right after abort_n transfers).
  task automatic run_frame(input int c_cfg, input int r, input int gap, input bit spam, input int abort_n);
    int c, n, idx, budget, m;
    bit v, rdy;
    int exp_q[$];
    c = c_cfg & ~1;
    n = c * r;
    idx = 0;
    budget = 0;
    win_cyc.delete(); out_cyc.delete(); done_cyc.delete();
    out_q.delete(); win_q.delete(); last_q.delete();
    for (int rr = 0; rr < r; rr += 2)
      for (int cc = 0; cc < c; cc += 2) begin
        m = frame_pix[rr*c + cc];
        if (frame_pix[rr*c + cc + 1] > m) m = frame_pix[rr*c + cc + 1];
        if (frame_pix[(rr+1)*c + cc] > m) m = frame_pix[(rr+1)*c + cc];
        if (frame_pix[(rr+1)*c + cc + 1] > m) m = frame_pix[(rr+1)*c + cc + 1];
        exp_q.push_back(m);
      end
    start = 1'b1; cfg_cols = 10'(c_cfg); cfg_rows = 10'(r);
    @(posedge clk); #1;
    start = spam;
    if (spam) begin cfg_cols = 10'd8; cfg_rows = 10'd2; end
    while (idx < n && budget < 20000 && !(abort_n > 0 && idx >= abort_n)) begin
      v = ($urandom_range(99) >= gap);
      in_valid = v;
      in_data = W'(frame_pix[idx]);
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (v && rdy) idx++;
      budget++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort_n > 0) return;
    check("feed_complete", idx, n);
    budget = 0;
    while (done_cyc.size() == 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    check("done_seen", done_cyc.size(), 1);
    check("out_count", out_q.size(), exp_q.size());
    check("win_count", win_cyc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check("out_data", out_q[i], exp_q[i]);
      check("out_last", last_q[i], (i == exp_q.size() - 1) ? 1 : 0);
      if (i < win_cyc.size()) check("latency", out_cyc[i] - win_cyc[i], 3);
    end
    if (done_cyc.size() > 0 && out_cyc.size() > 0)
      check("done_after_last", done_cyc[0], out_cyc[out_cyc.size()-1] + 1);
    check("in_ready_outside_run", rdy_viol, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x4 ramp, no gaps
    fill(0, 16);
    run_frame(4, 4, 0, 1'b0, 0);
    if (out_q.size() == 4) begin
      check("ramp_0", out_q[0], 5);
      check("ramp_1", out_q[1], 7);
      check("ramp_2", out_q[2], 13);
      check("ramp_3", out_q[3], 15);
    end else check("ramp_count", out_q.size(), 4);

    // 2x2 signed window
    frame_pix.delete();
    frame_pix.push_back(-128); frame_pix.push_back(-1);
    frame_pix.push_back(-2);   frame_pix.push_back(-3);
    run_frame(2, 2, 0, 1'b0, 0);
    if (win_q.size() == 4) begin
      check("win_1_1", win_q[0], -128);
      check("win_1_2", win_q[1], -1);
      check("win_2_1", win_q[2], -2);
      check("win_2_2", win_q[3], -3);
    end else check("signed_win_count", win_q.size(), 4);
    if (out_q.size() == 1) check("signed_out", out_q[0], -1);

    // full-width frame with ~50% input gaps
    fill(1, 832);
    run_frame(416, 2, 50, 1'b0, 0);

    // odd cfg_cols rounds down; start during RUN is ignored
    fill(1, 16);
    run_frame(5, 4, 30, 1'b1, 0);

    // abort mid odd row
    fill(1, 16);
    run_frame(4, 4, 0, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    check("abort_win_valid", win_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_win_1_1", win_1_1, 0);
    check("abort_win_2_2", win_2_2, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    out_q.delete(); done_cyc.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_out", out_q.size(), 0);
    check("abort_no_done", done_cyc.size(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill(1, 16);
    run_frame(4, 4, 20, 1'b0, 0);

    // back-to-back: start in the cycle right after done
    fill(1, 16);
    run_frame(4, 4, 0, 1'b0, 0);
    fill(1, 32);
    run_frame(8, 4, 10, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
